// File: rtl/pagerank_reducer.sv
// pagerank_reducer: sums nterms mapper partial sums per row and emits them row-tagged
//
// Ports:
//   clk      clock, state updates on posedge
//   reset    asynchronous active-low reset
//   in_val   partial-sum valid
//   in_rdy   reducer can accept a partial sum (high while accumulating)
//   in_msg   partial sum from mapper
//   out_val  result valid (high while a result is held)
//   out_rdy  writeback accepts result
//   out_msg  accumulated rank entry
//   out_row  row index of out_msg
//   out_last out_msg is the final row of the rank vector
//   busy     a row is partly accumulated or a result is held
module pagerank_reducer #(
    parameter int nbits  = 32,
    parameter int nterms = 4,
    parameter int nrows  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [nbits-1:0]         in_msg,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [nbits-1:0]         out_msg,
    output logic [$clog2(nrows)-1:0] out_row,
    output logic                     out_last,
    output logic                     busy
);
    localparam int cw = $clog2(nterms);
    localparam int rw = $clog2(nrows);
    localparam logic [0:0] ACC = 1'b0;
    localparam logic [0:0] OUT = 1'b1;
    localparam logic [cw-1:0] last_term = cw'(nterms - 1);
    localparam logic [rw-1:0] last_row  = rw'(nrows - 1);

    logic [0:0]       state;
    logic [nbits-1:0] acc;
    logic [cw-1:0]    term_cnt;
    logic [rw-1:0]    row_cnt;
    logic             xfer;
    logic [nbits-1:0] sum;

    // in_msg only reaches state through a transfer, so X on idle cycles is harmless
    assign xfer    = in_val && in_rdy;
    assign sum     = acc + in_msg;
    assign in_rdy  = (state == ACC);
    assign out_val = (state == OUT);
    assign busy    = (state == OUT) || (term_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ACC;
            acc      <= '0;
            term_cnt <= '0;
            row_cnt  <= '0;
            out_msg  <= '0;
            out_row  <= '0;
            out_last <= 1'b0;
        end else if (state == ACC) begin
            if (xfer) begin
                if (term_cnt == last_term) begin
                    out_msg  <= sum;
                    out_row  <= row_cnt;
                    out_last <= (row_cnt == last_row);
                    acc      <= '0;
                    term_cnt <= '0;
                    state    <= OUT;
                end else begin
                    acc      <= sum;
                    term_cnt <= term_cnt + 1'b1;
                end
            end
        end else if (out_rdy) begin
            state   <= ACC;
            row_cnt <= (row_cnt == last_row) ? '0 : row_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pagerank_reducer.sv
// tb_pagerank_reducer: directed table-driven checks of pagerank_reducer
module tb_pagerank_reducer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [31:0] in_msg = '0;
    logic        out_val;
    logic        out_rdy = 1'b1;
    logic [31:0] out_msg;
    logic [1:0]  out_row;
    logic        out_last;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] t0, t1, t2, t3;
        int          g0, g1, g2, g3;
        logic [31:0] msg;
        logic [1:0]  row;
        logic        last;
    } vec_t;

    vec_t vecs[5];

    pagerank_reducer #(.nbits(32), .nterms(4), .nrows(4)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_row(out_row),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, c, d, input int ga, gb, gc, gd,
                                input logic [31:0] m, input logic [1:0] r, input logic l);
        vec_t v;
        v.t0 = a; v.t1 = b; v.t2 = c; v.t3 = d;
        v.g0 = ga; v.g1 = gb; v.g2 = gc; v.g3 = gd;
        v.msg = m; v.row = r; v.last = l;
        return v;
    endfunction

    // entered and left at posedge+1; gap idle cycles precede the transfer
    task automatic send(input logic [31:0] d, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_val = 1'b1;
        in_msg = d;
        @(negedge clk);
        chk("in_rdy_accept", {31'd0, in_rdy}, 32'd1);
        chk("out_val_low_acc", {31'd0, out_val}, 32'd0);
        @(posedge clk);
        #1;
        in_val = 1'b0;
        in_msg = 'x;
    endtask

    task automatic send_row(input vec_t v);
        send(v.t0, v.g0);
        @(negedge clk);
        chk("busy_mid_row", {31'd0, busy}, 32'd1);
        #6;
        send(v.t1, v.g1);
        send(v.t2, v.g2);
        send(v.t3, v.g3);
    endtask

    // checks one-cycle result with out_rdy already high
    task automatic expect_out(input string name, input logic [31:0] m, input logic [1:0] r, input logic l);
        @(negedge clk);
        chk({name, "_val"}, {31'd0, out_val}, 32'd1);
        chk({name, "_msg"}, out_msg, m);
        chk({name, "_row"}, {30'd0, out_row}, {30'd0, r});
        chk({name, "_last"}, {31'd0, out_last}, {31'd0, l});
        chk({name, "_in_rdy"}, {31'd0, in_rdy}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({name, "_val_drop"}, {31'd0, out_val}, 32'd0);
        chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = mk(32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 0, 32'd10, 2'd0, 1'b0);
        vecs[1] = mk(32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 0, 0, 0, 0, 32'd1, 2'd1, 1'b0);
        vecs[2] = mk(32'd7, 32'd8, 32'd9, 32'd10, 0, 2, 1, 0, 32'd34, 2'd2, 1'b0);
        vecs[3] = mk(32'd1, 32'd1, 32'd1, 32'd1, 0, 0, 0, 0, 32'd4, 2'd3, 1'b1);
        vecs[4] = mk(32'd1, 32'd1, 32'd1, 32'd1, 0, 0, 0, 0, 32'd4, 2'd0, 1'b0);

        #3;
        chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        chk("rst_out_val", {31'd0, out_val}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_msg", out_msg, 32'd0);
        chk("rst_out_row", {30'd0, out_row}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            send_row(vecs[i]);
            expect_out($sformatf("vec%0d", i), vecs[i].msg, vecs[i].row, vecs[i].last);
        end

        // backpressure: row 1 held for 5 cycles
        out_rdy = 1'b0;
        send_row(mk(32'd2, 32'd2, 32'd2, 32'd2, 0, 0, 0, 0, 32'd0, 2'd0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_val", {31'd0, out_val}, 32'd1);
            chk("bp_msg", out_msg, 32'd8);
            chk("bp_row", {30'd0, out_row}, 32'd1);
            chk("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        expect_out("bp_release", 32'd8, 2'd1, 1'b0);

        // async reset mid-row
        send(32'd5, 0);
        send(32'd6, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_out_val", {31'd0, out_val}, 32'd0);
        chk("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_row(vecs[4]);
        expect_out("post_rst", 32'd4, 2'd0, 1'b0);

        // async reset while holding a result
        out_rdy = 1'b0;
        send_row(vecs[4]);
        @(negedge clk);
        chk("hold_val", {31'd0, out_val}, 32'd1);
        reset = 1'b0;
        #1;
        chk("hold_rst_val", {31'd0, out_val}, 32'd0);
        chk("hold_rst_msg", out_msg, 32'd0);
        #1;
        reset = 1'b1;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;

        // five rows of ones from row 0 wrap back to row 0
        for (int i = 0; i < 5; i++) begin
            send_row(vecs[4]);
            expect_out($sformatf("wrap%0d", i), 32'd4, 2'(i % 4), (i % 4) == 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
